// File: rtl/pow_n_multi_cycle_handshake.sv
// Multi-cycle unsigned power unit: res = arg^exp mod 2^W, one multiply per cycle,
// ready/valid on both sides and a sticky overflow flag for the true result.
module pow_n_multi_cycle_handshake #(
  parameter int unsigned W     = 8,
  parameter int unsigned EXP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  input  logic [W-1:0]     arg,
  input  logic [EXP_W-1:0] exp,
  output logic             arg_rdy,
  output logic             res_vld,
  output logic [W-1:0]     res,
  output logic             res_ovf,
  input  logic             res_rdy
);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

  state_e           state_q;
  logic [W-1:0]     base_q;
  logic [EXP_W-1:0] cnt_q;
  logic [W-1:0]     acc_q;
  logic             ovf_q;
  logic [2*W-1:0]   prod;

  // Both operands zero-extended so the multiply keeps the full 2W-bit product.
  always_comb begin
    prod = {{W{1'b0}}, acc_q} * {{W{1'b0}}, base_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      base_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arg_vld) begin
            base_q  <= arg;
            cnt_q   <= exp;
            acc_q   <= {{(W-1){1'b0}}, 1'b1};
            ovf_q   <= 1'b0;
            state_q <= (exp == '0) ? StDone : StCalc;
          end
        end
        StCalc: begin
          acc_q <= prod[W-1:0];
          if (prod[2*W-1:W] != '0) begin
            ovf_q <= 1'b1;
          end
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == {{(EXP_W-1){1'b0}}, 1'b1}) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          if (res_rdy) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign arg_rdy = (state_q == StIdle);
  assign res_vld = (state_q == StDone);
  assign res     = acc_q;
  assign res_ovf = ovf_q;

endmodule
